// File: rtl/c64_bus_pkg.sv
// rtl/c64_bus_pkg.sv - shared types and constants for the C64 bus arbiter (ARB_DMA_EN adds DMA_OWN)
package c64_bus_pkg;

    localparam logic PHI1             = 1'b0;
    localparam logic PHI2             = 1'b1;
    localparam int   BA_DELAY_DEFAULT = 3;
    localparam int   BA_CNT_W         = 8;

`ifdef ARB_DMA_EN
    typedef enum logic [1:0] {
        CPU_OWN = 2'd0,
        BA_WAIT = 2'd1,
        VIC_OWN = 2'd2,
        DMA_OWN = 2'd3
    } arb_state_t;

    typedef struct packed {
        logic ba;
        logic aec;
        logic cpu_rdy;
        logic dma_gnt;
    } arb_flags_t;
`else
    typedef enum logic [1:0] {
        CPU_OWN = 2'd0,
        BA_WAIT = 2'd1,
        VIC_OWN = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic ba;
        logic aec;
        logic cpu_rdy;
    } arb_flags_t;
`endif

    // Handshake outputs that belong to each ownership state
    function automatic arb_flags_t flags_for(arb_state_t s);
        arb_flags_t f;
        f = '1;
        case (s)
            BA_WAIT: begin
                f.ba      = 1'b0;
                f.cpu_rdy = 1'b0;
            end
            VIC_OWN: begin
                f.ba      = 1'b0;
                f.aec     = 1'b0;
                f.cpu_rdy = 1'b0;
            end
`ifdef ARB_DMA_EN
            DMA_OWN: f.cpu_rdy = 1'b0;
`endif
            default: ;
        endcase
`ifdef ARB_DMA_EN
        f.dma_gnt = (s == DMA_OWN);
`endif
        return f;
    endfunction

endpackage

// File: rtl/arb_ba_timer.sv
// rtl/arb_ba_timer.sv - bus-available countdown between BA falling and the VIC taking phi2
module arb_ba_timer
    import c64_bus_pkg::*;
#(
    parameter int W = BA_CNT_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count;

    // Load on BA fall, then count down once per completed bus cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    // High when the decrement at the end of this bus cycle lands on zero,
    // so the FSM hands the slot over on exactly that edge
    assign zero = (count <= W'(1));

endmodule

// File: rtl/c64_bus_arbiter.sv
// rtl/c64_bus_arbiter.sv - phi1/phi2 bus arbiter for CPU, VIC badline and optional DMA (ARB_DMA_EN)
module c64_bus_arbiter
    import c64_bus_pkg::*;
#(
    parameter int BA_DELAY = BA_DELAY_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cpu_ab,
    input  logic [7:0]  cpu_do,
    input  logic        cpu_we,
    input  logic [15:0] vic_ab,
    input  logic        vic_badline,
`ifdef ARB_DMA_EN
    input  logic        dma_req,
    input  logic [15:0] dma_ab,
    input  logic [7:0]  dma_do,
    input  logic        dma_we,
    output logic        dma_gnt,
`endif
    output logic [15:0] mem_ab,
    output logic [7:0]  mem_do,
    output logic        mem_we,
    output logic        phi2,
    output logic        ba,
    output logic        aec,
    output logic        cpu_rdy
);

    logic       phase;
    arb_state_t state;
    arb_flags_t flags;
    logic       bus_end;
    logic       ba_load;
    logic       ba_dec;
    logic       ba_zero;

    // Ownership only changes on the edge that closes phi2
    assign bus_end = (phase == PHI2);

    // BA countdown starts whenever a badline is seen by an owner that is not yet waiting
    always_comb begin
        ba_load = 1'b0;
        if (bus_end && vic_badline) begin
            case (state)
                CPU_OWN: ba_load = 1'b1;
`ifdef ARB_DMA_EN
                DMA_OWN: ba_load = 1'b1;
`endif
                default: ba_load = 1'b0;
            endcase
        end
    end

    assign ba_dec = bus_end && (state == BA_WAIT);

    arb_ba_timer #(
        .W (BA_CNT_W)
    ) u_ba_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (ba_load),
        .load_val (BA_CNT_W'(BA_DELAY)),
        .dec      (ba_dec),
        .zero     (ba_zero)
    );

    // Phase toggle plus ownership FSM; handshake flags are registered with the state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase <= PHI1;
            state <= CPU_OWN;
            flags <= flags_for(CPU_OWN);
        end else begin
            phase <= ~phase;
            if (bus_end) begin
                case (state)
                    CPU_OWN: begin
                        if (vic_badline) begin
                            if (BA_DELAY == 0) begin
                                state <= VIC_OWN;
                                flags <= flags_for(VIC_OWN);
                            end else begin
                                state <= BA_WAIT;
                                flags <= flags_for(BA_WAIT);
                            end
                        end
`ifdef ARB_DMA_EN
                        else if (dma_req) begin
                            state <= DMA_OWN;
                            flags <= flags_for(DMA_OWN);
                        end
`endif
                    end
                    BA_WAIT: begin
                        if (!vic_badline) begin
                            state <= CPU_OWN;
                            flags <= flags_for(CPU_OWN);
                        end else if (ba_zero) begin
                            state <= VIC_OWN;
                            flags <= flags_for(VIC_OWN);
                        end
                    end
                    VIC_OWN: begin
                        if (!vic_badline) begin
                            state <= CPU_OWN;
                            flags <= flags_for(CPU_OWN);
                        end
                    end
`ifdef ARB_DMA_EN
                    DMA_OWN: begin
                        if (vic_badline) begin
                            if (BA_DELAY == 0) begin
                                state <= VIC_OWN;
                                flags <= flags_for(VIC_OWN);
                            end else begin
                                state <= BA_WAIT;
                                flags <= flags_for(BA_WAIT);
                            end
                        end else if (!dma_req) begin
                            state <= CPU_OWN;
                            flags <= flags_for(CPU_OWN);
                        end
                    end
`endif
                    default: begin
                        state <= CPU_OWN;
                        flags <= flags_for(CPU_OWN);
                    end
                endcase
            end
        end
    end

    assign phi2    = phase;
    assign ba      = flags.ba;
    assign aec     = flags.aec;
    assign cpu_rdy = flags.cpu_rdy;
`ifdef ARB_DMA_EN
    assign dma_gnt = flags.dma_gnt;
`endif

    // Zero-latency bus mux: VIC always has phi1, the current owner has phi2
    always_comb begin
        mem_ab = vic_ab;
        mem_do = cpu_do;
        mem_we = 1'b0;
`ifdef ARB_DMA_EN
        if (state == DMA_OWN) begin
            mem_do = dma_do;
        end
`endif
        if (phase == PHI2) begin
            case (state)
                CPU_OWN, BA_WAIT: begin
                    mem_ab = cpu_ab;
                    mem_we = cpu_we;
                end
`ifdef ARB_DMA_EN
                DMA_OWN: begin
                    mem_ab = dma_ab;
                    mem_we = dma_we;
                end
`endif
                default: begin
                    mem_ab = vic_ab;
                    mem_we = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_c64_bus_arbiter.sv
// tb/tb_c64_bus_arbiter.sv - randomized bench for c64_bus_arbiter, BA_DELAY=3 and BA_DELAY=0 side by side
`timescale 1ns/1ps
module tb_c64_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] cpu_ab;
    logic [7:0]  cpu_do;
    logic        cpu_we;
    logic [15:0] vic_ab;
    logic        vic_badline;
    logic        dma_req;
    logic [15:0] dma_ab;
    logic [7:0]  dma_do;
    logic        dma_we;

    logic [15:0] mem_ab_a, mem_ab_z;
    logic [7:0]  mem_do_a, mem_do_z;
    logic        mem_we_a, mem_we_z;
    logic        phi2_a, phi2_z;
    logic        ba_a, ba_z;
    logic        aec_a, aec_z;
    logic        cpu_rdy_a, cpu_rdy_z;
`ifdef ARB_DMA_EN
    logic        dma_gnt_a, dma_gnt_z;
`endif

    int errors = 0;
    int checks = 0;

    // Reference model: length of the current badline run (in bus cycles),
    // whether DMA holds phi2, and the phase of the current half cycle
    int age     = 0;
    bit dma_own = 1'b0;
    bit m_phase = 1'b0;

    always #5 clk = ~clk;

    c64_bus_arbiter #(.BA_DELAY(3)) dut_a (
        .clk         (clk),
        .reset       (reset),
        .cpu_ab      (cpu_ab),
        .cpu_do      (cpu_do),
        .cpu_we      (cpu_we),
        .vic_ab      (vic_ab),
        .vic_badline (vic_badline),
`ifdef ARB_DMA_EN
        .dma_req     (dma_req),
        .dma_ab      (dma_ab),
        .dma_do      (dma_do),
        .dma_we      (dma_we),
        .dma_gnt     (dma_gnt_a),
`endif
        .mem_ab      (mem_ab_a),
        .mem_do      (mem_do_a),
        .mem_we      (mem_we_a),
        .phi2        (phi2_a),
        .ba          (ba_a),
        .aec         (aec_a),
        .cpu_rdy     (cpu_rdy_a)
    );

    c64_bus_arbiter #(.BA_DELAY(0)) dut_z (
        .clk         (clk),
        .reset       (reset),
        .cpu_ab      (cpu_ab),
        .cpu_do      (cpu_do),
        .cpu_we      (cpu_we),
        .vic_ab      (vic_ab),
        .vic_badline (vic_badline),
`ifdef ARB_DMA_EN
        .dma_req     (dma_req),
        .dma_ab      (dma_ab),
        .dma_do      (dma_do),
        .dma_we      (dma_we),
        .dma_gnt     (dma_gnt_z),
`endif
        .mem_ab      (mem_ab_z),
        .mem_do      (mem_do_z),
        .mem_we      (mem_we_z),
        .phi2        (phi2_z),
        .ba          (ba_z),
        .aec         (aec_z),
        .cpu_rdy     (cpu_rdy_z)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Compare one DUT against the model: d=0 is BA_DELAY=3, d=1 is BA_DELAY=0
    task automatic check_dut(input int d);
        int          dly;
        bit          own_vic, own_dma;
        logic [15:0] e_ab;
        logic [7:0]  e_do;
        logic        e_we;
        dly     = (d == 0) ? 3 : 0;
        own_vic = (age > dly);
        own_dma = !own_vic && (age == 0) && dma_own;
        e_ab    = (m_phase && !own_vic) ? (own_dma ? dma_ab : cpu_ab) : vic_ab;
        e_we    = m_phase && !own_vic && (own_dma ? dma_we : cpu_we);
        e_do    = own_dma ? dma_do : cpu_do;
        check($sformatf("D%0d phi2", dly),    32'((d == 0) ? phi2_a    : phi2_z),    32'(m_phase));
        check($sformatf("D%0d ba", dly),      32'((d == 0) ? ba_a      : ba_z),      32'(age == 0));
        check($sformatf("D%0d aec", dly),     32'((d == 0) ? aec_a     : aec_z),     32'(!own_vic));
        check($sformatf("D%0d cpu_rdy", dly), 32'((d == 0) ? cpu_rdy_a : cpu_rdy_z), 32'((age == 0) && !dma_own));
        check($sformatf("D%0d mem_ab", dly),  32'((d == 0) ? mem_ab_a  : mem_ab_z),  32'(e_ab));
        check($sformatf("D%0d mem_we", dly),  32'((d == 0) ? mem_we_a  : mem_we_z),  32'(e_we));
        if (!own_vic) begin
            check($sformatf("D%0d mem_do", dly), 32'((d == 0) ? mem_do_a : mem_do_z), 32'(e_do));
        end
`ifdef ARB_DMA_EN
        check($sformatf("D%0d dma_gnt", dly), 32'((d == 0) ? dma_gnt_a : dma_gnt_z), 32'(own_dma));
`endif
    endtask

    // Advance one clk: update the model at the closing edge of phi2, check on the falling edge
    task automatic step();
        int prev;
        @(posedge clk);
        if (!reset) begin
            age     = 0;
            dma_own = 1'b0;
            m_phase = 1'b0;
        end else begin
            if (m_phase) begin
                prev = age;
                age  = vic_badline ? ((age < 1000) ? age + 1 : age) : 0;
                dma_own = (age == 0) && (prev == 0) && dma_req;
            end
            m_phase = !m_phase;
        end
        @(negedge clk);
        check_dut(0);
        check_dut(1);
    endtask

    task automatic randomize_inputs();
        cpu_ab = 16'($urandom);
        cpu_do = 8'($urandom);
        cpu_we = 1'($urandom);
        vic_ab = 16'($urandom);
        dma_ab = 16'($urandom);
        dma_do = 8'($urandom);
        dma_we = 1'($urandom);
        if ($urandom_range(0, 11) == 0) vic_badline = !vic_badline;
`ifdef ARB_DMA_EN
        if ($urandom_range(0, 7) == 0) dma_req = !dma_req;
`endif
    endtask

    initial begin
        reset       = 1'b0;
        cpu_ab      = 16'h1000;
        cpu_do      = 8'hA9;
        cpu_we      = 1'b1;
        vic_ab      = 16'h0400;
        vic_badline = 1'b0;
        dma_req     = 1'b0;
        dma_ab      = 16'hD000;
        dma_do      = 8'h5A;
        dma_we      = 1'b1;

        // Held in reset: phase 0 and idle handshake values despite cpu_we=1
        repeat (3) @(negedge clk);
        check_dut(0);
        check_dut(1);
        reset = 1'b1;

        // CPU write in phi2, VIC address in phi1
        repeat (4) step();

        // Held badline: BA wait then VIC takes phi2 (immediately for BA_DELAY=0)
        vic_badline = 1'b1;
        repeat (14) begin
            cpu_ab = 16'($urandom);
            cpu_we = 1'($urandom);
            vic_ab = 16'($urandom);
            step();
        end
        vic_badline = 1'b0;
        repeat (4) step();

        // Short badline: abandoned during the BA wait
        vic_badline = 1'b1;
        repeat (4) step();
        vic_badline = 1'b0;
        repeat (6) step();

`ifdef ARB_DMA_EN
        // DMA takes phi2 and hands it back
        dma_req = 1'b1;
        dma_ab  = 16'hD000;
        dma_we  = 1'b1;
        repeat (6) step();
        dma_req = 1'b0;
        repeat (4) step();

        // DMA request and badline together: badline wins
        dma_req     = 1'b1;
        vic_badline = 1'b1;
        repeat (10) step();
        vic_badline = 1'b0;
        repeat (4) step();
        dma_req = 1'b0;
        repeat (4) step();
`endif

        repeat (3000) begin
            randomize_inputs();
            step();
        end

        // Asynchronous reset in the middle of a VIC-owned phi2 half cycle
        vic_badline = 1'b1;
        dma_req     = 1'b0;
        repeat (12) step();
        if (!m_phase) step();
        #2;
        reset = 1'b0;
        #1;
        age     = 0;
        dma_own = 1'b0;
        m_phase = 1'b0;
        check_dut(0);
        check_dut(1);
        @(negedge clk);
        vic_badline = 1'b0;
        reset       = 1'b1;
        repeat (6) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
